// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, 32 iterations per op.
// Optional macro DIV_BY_ZERO_TRAP_EN: a divide by zero finishes early with div_zero set.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t      state;
    logic [5:0]  count;
    logic        op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic        q_m1;

    logic [31:0] a_in_mag;
    logic [31:0] b_mag;
    logic [32:0] booth_m;
    logic [32:0] booth_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;

    assign fsm_state = state;
    assign a_in_mag  = a_in[31] ? (32'd0 - a_in) : a_in;
    assign b_mag     = b_reg[31] ? (32'd0 - b_reg) : b_reg;

    // One extra adder bit keeps A +/- M exact when M is the most negative value.
    always_comb begin
        booth_m   = {a_reg[31], a_reg};
        booth_sum = {acc_hi[31], acc_hi};
        case ({acc_lo[0], q_m1})
            2'b01:   booth_sum = {acc_hi[31], acc_hi} + booth_m;
            2'b10:   booth_sum = {acc_hi[31], acc_hi} - booth_m;
            default: booth_sum = {acc_hi[31], acc_hi};
        endcase
    end

    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = (div_shift >= {1'b0, b_mag});
    assign div_diff  = div_shift - {1'b0, b_mag};

`ifdef DIV_BY_ZERO_TRAP_EN
    logic dz_flag;
    assign div_zero = dz_flag;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= 6'd0;
            op_reg <= 1'b0;
            a_reg  <= 32'd0;
            b_reg  <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            q_m1   <= 1'b0;
            hi_out <= 32'd0;
            lo_out <= 32'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef DIV_BY_ZERO_TRAP_EN
            dz_flag <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_BY_ZERO_TRAP_EN
            dz_flag <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (op_start) begin
                        a_reg  <= a_in;
                        b_reg  <= b_in;
                        op_reg <= op_sel;
                        count  <= 6'd0;
                        acc_hi <= 32'd0;
                        acc_lo <= op_sel ? a_in_mag : b_in;
                        q_m1   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= op_sel ? DIV : MULT;
                    end
                end
                MULT: begin
                    if (count == 6'd32) begin
                        hi_out <= acc_hi;
                        lo_out <= acc_lo;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc_hi <= booth_sum[32:1];
                        acc_lo <= {booth_sum[0], acc_lo[31:1]};
                        q_m1   <= acc_lo[0];
                        count  <= count + 6'd1;
                    end
                end
                DIV: begin
`ifdef DIV_BY_ZERO_TRAP_EN
                    if (b_reg == 32'd0) begin
                        done    <= 1'b1;
                        dz_flag <= 1'b1;
                        state   <= DONE;
                    end else
`endif
                    if (count == 6'd32) begin
                        // Quotient truncates toward zero; remainder follows the dividend sign.
                        lo_out <= (a_reg[31] ^ b_reg[31]) ? (32'd0 - acc_lo) : acc_lo;
                        hi_out <= a_reg[31] ? (32'd0 - acc_hi) : acc_hi;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc_hi <= div_ge ? div_diff[31:0] : div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], div_ge};
                        count  <= count + 6'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // op_reg records the accepted operation for debug visibility alongside fsm_state.
    logic unused_op;
    assign unused_op = op_reg;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have input clk, 1 bit: clock; all state changes on the rising edge.
REQ-003 The block SHALL have input reset, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have input op_start, 1 bit: operation request from the control unit, sampled in IDLE only.
REQ-005 The block SHALL have input op_sel, 1 bit: 0 selects signed multiply, 1 selects signed divide.
REQ-006 The block SHALL have input a_in, 32 bits: multiplicand or dividend, captured at acceptance.
REQ-007 The block SHALL have input b_in, 32 bits: multiplier or divisor, captured at acceptance.
REQ-008 The block SHALL have output hi_out, 32 bits: HI register (product[63:32] or remainder).
REQ-009 The block SHALL have output lo_out, 32 bits: LO register (product[31:0] or quotient).
REQ-010 The block SHALL have output busy, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have output done, 1 bit: one-cycle pulse when the result is committed.
REQ-012 The block SHALL have output div_zero, 1 bit: one-cycle divide-by-zero flag, coincident with done.

Function
REQ-013 The FSM SHALL have the states IDLE, MULT, DIV and DONE.
REQ-014 On the edge ending cycle T, with IDLE and op_start=1, the block SHALL capture a_in, b_in and op_sel, clear its 6-bit iteration counter, and enter MULT or DIV.
REQ-015 MULT SHALL run 32 iterations of radix-2 Booth, one per cycle, on a 65-bit {HI,LO,q-1} accumulator in two's complement.
REQ-016 DIV SHALL run 32 iterations of restoring division on operand magnitudes, one per cycle.
REQ-017 DIV SHALL fix up signs at commit: quotient truncated toward zero; remainder takes the dividend's sign.
REQ-018 For 0x80000000 / 0xFFFFFFFF, DIV SHALL commit LO=0x80000000 and HI=0x00000000, with no flag.
REQ-019 After iteration 32, at edge T+33, the block SHALL enter DONE; hi_out/lo_out SHALL update at that edge; done=1 during cycle T+34; the block SHALL return to IDLE at edge T+34.
REQ-020 hi_out/lo_out SHALL hold their value between operations; intermediate iteration values SHALL NOT appear on hi_out/lo_out.
REQ-021 While busy=1, op_start SHALL be ignored; no queuing.
REQ-022 In the DONE cycle, op_start SHALL be ignored; a new request is accepted only when the FSM is in IDLE.
REQ-023 a_in/b_in changes after acceptance SHALL NOT affect the running operation.

Reset
REQ-024 When reset=0, the block SHALL immediately force: FSM to IDLE, counter to 0, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, operand registers to 0.
REQ-025 Reset mid-operation SHALL abort the operation with no commit; the first request after reset release SHALL be accepted normally.

Configuration
REQ-026 Macro DIV_BY_ZERO_TRAP_EN defined: a DIV accepted with b_in=0 SHALL go IDLE->DONE at edge T+1, with done=1 and div_zero=1 in cycle T+2, and hi_out/lo_out unchanged.
REQ-027 Macro DIV_BY_ZERO_TRAP_EN undefined: div_zero SHALL be tied to 0; divide by zero SHALL run the full 32 iterations and commit HI=a_in, LO=0xFFFFFFFF (a_in>=0) or LO=0x00000001 (a_in<0).

Verification
REQ-028 MULT 6 x 7, start at T -> HI=0x00000000, LO=0x0000002A, done high in cycle T+34 only, busy high T+1..T+34.
REQ-029 MULT 0xFFFFFFFD x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-030 DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 DIV 100 / 0 with the macro -> done and div_zero high in cycle T+2, HI/LO unchanged; without the macro -> done at T+34, HI=0x00000064, LO=0xFFFFFFFF, div_zero=0.
REQ-032 Reset pulse at T+10 of a MULT -> all outputs 0 immediately, no done; a subsequent MULT 3 x 3 -> LO=9.
REQ-033 op_start held high throughout a MULT 2 x 2 -> exactly one commit, LO=4; a second operation is accepted in the first IDLE cycle after DONE.
